// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and response-tag types for the memory arbiter.
package mem_pkg;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } src_t;

    typedef struct packed {
        logic valid;
        src_t src;
    } tag_t;
endpackage

// File: rtl/rsp_tag_pipe.sv
// rsp_tag_pipe: RD_LAT-deep shift register of read tags, aligned with the memory read latency.
module rsp_tag_pipe import mem_pkg::*; #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic busy
);
    tag_t [RD_LAT-1:0] stages;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) stages[i] <= stages[i-1];
        end
    end

    assign tag_out = stages[RD_LAT-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) busy = busy | stages[i].valid;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store, D-priority with
// a starvation limit that forces a fetch grant, and routes read data back by tag.
module mem_arbiter #(
    parameter int ADDR_W     = mem_pkg::ADDR_W,
    parameter int DATA_W     = mem_pkg::DATA_W,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    import mem_pkg::*;

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          force_if, grant_d, grant_if;
    tag_t          tag_in, tag_out;

    assign force_if = starve_cnt == CW'(STARVE_MAX);
    // rst_n gating keeps every command and handshake quiet while reset is held
    assign grant_d  = rst_n & d_req_valid & ~halt & ~(force_if & if_req_valid);
    assign grant_if = rst_n & if_req_valid & ~halt & ~grant_d;

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;
    assign mem_en       = grant_if | grant_d;
    assign mem_we       = grant_d & d_req_we;
    assign mem_addr     = grant_d ? d_req_addr : grant_if ? if_req_addr : '0;
    assign mem_wdata    = mem_we ? d_req_wdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (!halt)
            starve_cnt <= (grant_if || !if_req_valid) ? '0 :
                          (grant_d && !force_if) ? starve_cnt + 1'b1 : starve_cnt;
    end

    always_comb begin
        tag_in.valid = mem_en & ~mem_we;
        tag_in.src   = grant_d ? SRC_D : SRC_IF;
    end

    rsp_tag_pipe #(.RD_LAT(RD_LAT)) u_tags (
        .clk    (clk),
        .rst_n  (rst_n),
        .tag_in (tag_in),
        .tag_out(tag_out),
        .busy   (busy)
    );

    assign if_rsp_valid = rst_n & tag_out.valid & (tag_out.src == SRC_IF);
    assign d_rsp_valid  = rst_n & tag_out.valid & (tag_out.src == SRC_D);
    assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
    assign d_rsp_data   = d_rsp_valid ? mem_rdata : '0;
endmodule
